tlul_host_arb: RTL

//  M:1 TL-UL host arbiter. Shares one downstream device port, e.g. the host side of a 1:N socket, among M hosts.

---
 rtl/tlul_host_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tlul_host_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tlul_host_arb (with tlul_pkg TL-UL channel types)
//  Purpose  : M:1 TL-UL host arbiter. Round-robin grant with lock-until-
//             accept, per-host outstanding-request limit, and host-index
//             tagging in the low bits of a_source so D responses route back.
//  Ports    : clk_i   - clock
//             rst_ni  - asynchronous active-low reset
//             tl_h_i  - host requests  [M]
//             tl_h_o  - host responses / a_ready [M]
//             tl_d_o  - merged request to the device
//             tl_d_i  - device response / a_ready
//  Revision : 1.0 - initial release
// ============================================================================
package tlul_pkg;
    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_AIW  = 8;
    localparam int TL_DIW  = 1;
    localparam int TL_SZW  = 2;
    localparam int TL_DBW  = TL_DW / 8;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb #(
    parameter int M        = 4,
    parameter int MaxOutst = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_h_i [M],
    output tlul_pkg::tl_d2h_t tl_h_o [M],
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i
);
    import tlul_pkg::*;

    localparam int IdW  = $clog2(M);
    localparam int CntW = $clog2(MaxOutst + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutst);

    logic [CntW-1:0] cnt [M];
    logic            lock;
    logic [IdW-1:0]  held_gnt;
    logic [IdW-1:0]  rr_ptr;

    logic [M-1:0]    elig;
    logic            any_elig;
    logic [IdW-1:0]  arb_gnt;
    logic [IdW-1:0]  gnt;
    logic            a_valid_int;
    logic            a_acc;
    logic [IdW-1:0]  did;
    logic            did_ok;
    logic            d_ready_int;
    logic            d_acc;
    logic [M-1:0]    inc;
    logic [M-1:0]    dec;

    // ---------------- arbitration ----------------
    always_comb begin
        for (int i = 0; i < M; i++) begin
            elig[i] = tl_h_i[i].a_valid && (cnt[i] != CntMax);
        end
    end

    // Scan from the far end so the nearest eligible host after rr_ptr wins
    // by being written last.
    always_comb begin
        int idx;
        any_elig = 1'b0;
        arb_gnt  = rr_ptr;
        idx      = 0;
        for (int k = M; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % M;
            if (elig[idx]) begin
                any_elig = 1'b1;
                arb_gnt  = IdW'(idx);
            end
        end
    end

    assign gnt         = lock ? held_gnt : arb_gnt;
    // Outputs are forced inactive while reset is asserted, even if hosts
    // keep driving a_valid.
    assign a_valid_int = rst_ni && (lock || any_elig);
    assign a_acc       = a_valid_int && tl_d_i.a_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock     <= 1'b0;
            held_gnt <= '0;
            rr_ptr   <= IdW'(M - 1);
        end else if (a_valid_int) begin
            if (tl_d_i.a_ready) begin
                lock   <= 1'b0;
                rr_ptr <= gnt;
            end else begin
                lock     <= 1'b1;
                held_gnt <= gnt;
            end
        end
    end

    // ---------------- D routing ----------------
    assign did         = tl_d_i.d_source[IdW-1:0];
    assign did_ok      = int'(did) < M;
    // Tags that map to no host are sunk so the device never stalls on them.
    assign d_ready_int = rst_ni && (did_ok ? tl_h_i[did].d_ready : 1'b1);
    assign d_acc       = tl_d_i.d_valid && d_ready_int;

    always_comb begin
        tl_d_o          = tl_h_i[gnt];
        tl_d_o.a_valid  = a_valid_int;
        tl_d_o.a_source = {tl_h_i[gnt].a_source[TL_AIW-IdW-1:0], gnt};
        tl_d_o.d_ready  = d_ready_int;
    end

    always_comb begin
        for (int i = 0; i < M; i++) begin
            tl_h_o[i]          = tl_d_i;
            tl_h_o[i].d_source = tl_d_i.d_source >> IdW;
            tl_h_o[i].d_valid  = rst_ni && tl_d_i.d_valid && did_ok && (did == IdW'(i));
            tl_h_o[i].a_ready  = a_acc && (gnt == IdW'(i));
        end
    end

    // ---------------- outstanding counters ----------------
    always_comb begin
        for (int i = 0; i < M; i++) begin
            inc[i] = a_acc && (gnt == IdW'(i));
            dec[i] = d_acc && did_ok && (did == IdW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < M; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // ---------------- protocol checks ----------------
    for (genvar i = 0; i < M; i++) begin : g_sva
        a_src_tag_free : assert property (@(posedge clk_i) disable iff (!rst_ni)
            tl_h_i[i].a_valid |-> (tl_h_i[i].a_source[TL_AIW-1 -: IdW] == '0));
        cnt_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (dec[i] && !inc[i]) |-> (cnt[i] != '0));
        cnt_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (inc[i] && !dec[i]) |-> (cnt[i] != CntMax));
    end

    d_tag_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        tl_d_i.d_valid |-> did_ok);

endmodule
`default_nettype wire
